// File: rtl/reg_wb_pipe.sv
// reg_wb_pipe: MEM/WB pipeline stage with a valid/ready handshake, a 2-entry
// skid buffer (output register + one skid register), synchronous flush and
// load-data formatting (lane select plus sign/zero extension) ahead of the
// output register.
// Optional build macro: WB_RETIRE_CNT_EN adds a 32-bit retire_count output
// counting emitted beats that write a register.
module reg_wb_pipe #(
   parameter int unsigned DATA_W             = 32,
   parameter int unsigned ADDR_W             = 5,
   parameter int unsigned ZERO_REG_HARDWIRED = 1,
   localparam int unsigned OFF_W             = $clog2(DATA_W / 8)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] alu_result_in,
   input  logic [DATA_W-1:0] mem_rd_in,
   input  logic [DATA_W-1:0] link_in,
   input  logic [1:0]        wb_sel_in,
   input  logic [1:0]        ld_size_in,
   input  logic              ld_signed_in,
   input  logic [OFF_W-1:0]  byte_off_in,
   input  logic [ADDR_W-1:0] write_reg_addr_in,
   input  logic              reg_write_in,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] write_back_data,
   output logic [ADDR_W-1:0] write_reg_addr,
   output logic              reg_write
`ifdef WB_RETIRE_CNT_EN
   ,
   output logic [31:0]       retire_count
`endif
);

   localparam logic [DATA_W-1:0] ONES = '1;

   typedef enum logic [1:0] {
      ST_EMPTY,
      ST_ONE,
      ST_TWO
   } state_t;

   state_t              state_q;
   logic                out_valid_q;
   logic                in_ready_q;
   logic [DATA_W-1:0]   data_q;
   logic [ADDR_W-1:0]   addr_q;
   logic                wen_q;
   logic [DATA_W-1:0]   skid_data_q;
   logic [ADDR_W-1:0]   skid_addr_q;
   logic                skid_wen_q;

   logic [1:0]          eff_size;
   logic [OFF_W-1:0]    aligned_off;
   logic [DATA_W-1:0]   lane;
   logic [DATA_W-1:0]   ext_mask;
   logic                sign_bit;
   logic [DATA_W-1:0]   ld_fmt;
   logic [DATA_W-1:0]   wb_data_d;
   logic                wen_d;
   logic                accept;
   logic                emit;

   assign accept = in_valid & in_ready_q;
   assign emit   = out_valid_q & out_ready;

   // Effective load size and naturally-aligned byte offset of the lane
   always_comb begin
      eff_size = ld_size_in;
      if (DATA_W == 32 && ld_size_in == 2'd3) begin
         eff_size = 2'd2;
      end
      case (eff_size)
         2'd0:    aligned_off = byte_off_in;
         2'd1:    aligned_off = byte_off_in & ~OFF_W'(1);
         2'd2:    aligned_off = byte_off_in & ~OFF_W'(3);
         default: aligned_off = '0;
      endcase
   end

   assign lane = mem_rd_in >> {aligned_off, 3'b000};

   // Sub-word extension: keep the low lane bits, fill the rest with the sign
   // bit or zero; a full-width lane gets an all-ones mask and passes through
   always_comb begin
      case (eff_size)
         2'd0: begin
            ext_mask = ONES >> (DATA_W - 8);
            sign_bit = lane[7];
         end
         2'd1: begin
            ext_mask = ONES >> (DATA_W - 16);
            sign_bit = lane[15];
         end
         2'd2: begin
            ext_mask = ONES >> (DATA_W - 32);
            sign_bit = lane[31];
         end
         default: begin
            ext_mask = ONES;
            sign_bit = lane[DATA_W-1];
         end
      endcase
      ld_fmt = (lane & ext_mask) | ({DATA_W{ld_signed_in & sign_bit}} & ~ext_mask);
   end

   // Write-back source select and write-enable qualification for the new beat
   always_comb begin
      case (wb_sel_in)
         2'd1:    wb_data_d = ld_fmt;
         2'd2:    wb_data_d = link_in;
         default: wb_data_d = alu_result_in;
      endcase
      wen_d = reg_write_in &
              !((ZERO_REG_HARDWIRED != 0) && (write_reg_addr_in == '0));
   end

   // Handshake FSM with output register and skid register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_EMPTY;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         data_q      <= '0;
         addr_q      <= '0;
         wen_q       <= 1'b0;
         skid_data_q <= '0;
         skid_addr_q <= '0;
         skid_wen_q  <= 1'b0;
      end else if (flush) begin
         state_q     <= ST_EMPTY;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (accept) begin
                  data_q      <= wb_data_d;
                  addr_q      <= write_reg_addr_in;
                  wen_q       <= wen_d;
                  out_valid_q <= 1'b1;
                  state_q     <= ST_ONE;
               end
            end
            ST_ONE: begin
               if (accept && emit) begin
                  data_q <= wb_data_d;
                  addr_q <= write_reg_addr_in;
                  wen_q  <= wen_d;
               end else if (accept) begin
                  skid_data_q <= wb_data_d;
                  skid_addr_q <= write_reg_addr_in;
                  skid_wen_q  <= wen_d;
                  in_ready_q  <= 1'b0;
                  state_q     <= ST_TWO;
               end else if (emit) begin
                  out_valid_q <= 1'b0;
                  state_q     <= ST_EMPTY;
               end
            end
            ST_TWO: begin
               if (emit) begin
                  data_q     <= skid_data_q;
                  addr_q     <= skid_addr_q;
                  wen_q      <= skid_wen_q;
                  in_ready_q <= 1'b1;
                  state_q    <= ST_ONE;
               end
            end
            default: begin
               state_q     <= ST_EMPTY;
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready        = in_ready_q;
   assign out_valid       = out_valid_q;
   assign write_back_data = data_q;
   assign write_reg_addr  = addr_q;
   assign reg_write       = out_valid_q & wen_q;

`ifdef WB_RETIRE_CNT_EN
   logic [31:0] retire_q;

   // Count emitted register-writing beats; a beat at a flush edge is dropped
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         retire_q <= '0;
      end else if (!flush && emit && wen_q) begin
         retire_q <= retire_q + 32'd1;
      end
   end

   assign retire_count = retire_q;
`endif

endmodule
